// File: rtl/lap_stopwatch_if.sv
// Pad-level bundle for the lap stopwatch: raw buttons and mode switch in,
// multiplexed active-low seven-segment display and status LEDs out.
interface lap_stopwatch_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                  start;
    logic                  stop;
    logic                  lap;
    logic                  inc;
    logic                  down;
    logic                  a;
    logic                  b;
    logic                  c;
    logic                  d;
    logic                  e;
    logic                  f;
    logic                  g;
    logic                  dp;
    logic [NUM_DIGITS-1:0] an;
    logic [1:0]            led;

    modport master (
        output start, stop, lap, inc, down,
        input  a, b, c, d, e, f, g, dp, an, led
    );

    modport slave (
        input  start, stop, lap, inc, down,
        output a, b, c, d, e, f, g, dp, an, led
    );
endinterface

// File: rtl/lap_stopwatch.sv
// BCD up/down stopwatch with lap snapshot, edge-detected buttons and a scanned
// common-anode seven-segment display.
module lap_stopwatch #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 1000000,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned DP_POS     = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    lap_stopwatch_if.slave pads_io
);
    localparam int unsigned CW = 4 * NUM_DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PreMax  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] ScanMax = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IdxMax  = IW'(NUM_DIGITS - 1);

    localparam int unsigned BtnStart = 0;
    localparam int unsigned BtnStop  = 1;
    localparam int unsigned BtnLap   = 2;
    localparam int unsigned BtnInc   = 3;

    typedef enum logic [1:0] {StStopped, StRunning, StLap} state_e;

    state_e          state_q, state_d;
    logic [4:0]      btn_raw, sync1_q, sync2_q;
    logic [3:0]      prev_q, pulse, sel;
    logic            down_s;
    logic [CW-1:0]   count_q, count_d, snap_q, snap_d, stepped, shown;
    logic [PW-1:0]   pre_q, pre_d;
    logic [SW-1:0]   scan_q, scan_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            mode_q, mode_d, ovf_q, ovf_d;
    logic            tick, expired;
    logic [3:0]      digit;
    logic [6:0]      seg;

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign btn_raw = {pads_io.down, pads_io.inc, pads_io.lap, pads_io.stop, pads_io.start};
    assign pulse   = sync2_q[3:0] & ~prev_q;
    assign down_s  = sync2_q[4];

    // Only the highest-priority pulse in a cycle survives.
    always_comb begin
        sel = '0;
        if (pulse[BtnStop])       sel[BtnStop]  = 1'b1;
        else if (pulse[BtnStart]) sel[BtnStart] = 1'b1;
        else if (pulse[BtnLap])   sel[BtnLap]   = 1'b1;
        else if (pulse[BtnInc])   sel[BtnInc]   = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        snap_d  = snap_q;
        pre_d   = pre_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        tick    = 1'b0;
        expired = 1'b0;
        stepped = count_q;

        if (state_q != StStopped) begin
            if (pre_q == PreMax) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end

        if (tick) begin
            stepped = mode_q ? bcd_dec(count_q) : bcd_inc(count_q);
            count_d = stepped;
            if (stepped == '0) begin
                if (mode_q) expired = 1'b1;
                else        ovf_d   = 1'b1;
            end
        end

        // A down-count reaching zero overrides any button action this cycle.
        if (expired) begin
            state_d = StStopped;
            ovf_d   = 1'b1;
        end else begin
            unique case (state_q)
                StStopped: begin
                    if (sel[BtnStop]) begin
                        count_d = '0;
                        pre_d   = '0;
                        ovf_d   = 1'b0;
                    end else if (sel[BtnStart] && !(down_s && count_q == '0)) begin
                        state_d = StRunning;
                        mode_d  = down_s;
                    end else if (sel[BtnInc]) begin
                        count_d = bcd_inc(count_q);
                    end
                end
                StRunning: begin
                    if (sel[BtnStop]) begin
                        state_d = StStopped;
                    end else if (sel[BtnLap]) begin
                        state_d = StLap;
                        snap_d  = count_q;
                    end
                end
                StLap: begin
                    if (sel[BtnStop])     state_d = StStopped;
                    else if (sel[BtnLap]) state_d = StRunning;
                end
                default: state_d = StStopped;
            endcase
        end
    end

    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == ScanMax) begin
            scan_d = '0;
            idx_d  = (idx_q == IdxMax) ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            state_q <= StStopped;
            count_q <= '0;
            snap_q  <= '0;
            pre_q   <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q[3:0];
            state_q <= state_d;
            count_q <= count_d;
            snap_q  <= snap_d;
            pre_q   <= pre_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
        end
    end

    assign shown = (state_q == StLap) ? snap_q : count_q;
    assign digit = shown[{idx_q, 2'b00} +: 4];

    // seg = {a, b, c, d, e, f, g}, active low
    always_comb begin
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    end

    assign {pads_io.a, pads_io.b, pads_io.c, pads_io.d, pads_io.e, pads_io.f, pads_io.g} = seg;
    assign pads_io.an  = ~(NUM_DIGITS'(1) << idx_q);
    assign pads_io.dp  = ~(32'(idx_q) == DP_POS);
    assign pads_io.led = {ovf_q, state_q != StStopped};
endmodule
